dmem_access_unit: RTL and testbench

- CPU-side initiator for the byte-array data memory; sits in the MEM stage between the pipeline and the data memory.
- Turns one load/store request (byte, half, word; signed or unsigned loads) into memory transactions.
- The memory writes one byte per MemWrite cycle, so stores are serialised into byte writes.
- The memory returns 4 little-endian bytes one clock after MemRead, so loads are captured one cycle later, then extracted and extended.
- Raises busy_o to stall the pipeline while a request is in flight.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_access_unit_load_extend.sv | 27 ++
 rtl/dmem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states,
// default memory size and a size-to-byte-count helper.
package dmem_pkg;

    localparam int unsigned MEM_BYTES_DEF = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_CAP = 3'd2,
        ST_WR     = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    // Reserved size reports zero bytes; such requests are rejected anyway.
    function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_nbytes = 3'd1;
            SZ_HALF: size_nbytes = 3'd2;
            SZ_WORD: size_nbytes = 3'd4;
            default: size_nbytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// Combinational load formatter: picks the low byte/half of the returned memory
// word and sign- or zero-extends it; words pass straight through.
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic sign_byte;
    logic sign_half;

    assign sign_byte = ~unsigned_i & word_i[7];
    assign sign_half = ~unsigned_i & word_i[15];

    always_comb begin
        result_o = word_i;
        case (size_i)
            SZ_BYTE: result_o = {{24{sign_byte}}, word_i[7:0]};
            SZ_HALF: result_o = {{16{sign_half}}, word_i[15:0]};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage initiator for the byte-wide data memory: serialises stores into
// byte writes and performs one-cycle-latency word reads for loads.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start_i; request is checked and latched here
//   ST_RD_REQ | mem_read_o asserted at the latched address
//   ST_RD_CAP | memory word valid; extended result captured into rdata
//   ST_WR     | one byte write per cycle, counter selects byte lane
//   ST_ERR    | rejected request; done_o/err_o pulse, no memory access
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              is_store_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [31:0]       mem_data_i
);

    localparam logic [ADDR_W:0] MEM_END = (ADDR_W+1)'(MEM_BYTES);

    state_e            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [2:0]        req_nbytes;
    logic [ADDR_W:0]   req_end;
    logic              req_bad;
    logic [2:0]        last_idx;
    logic              wr_last;
    logic [31:0]       ext_data;
    logic [7:0]        wr_byte;

    // One extra bit on the end address so a wrap near the top of the
    // address space still counts as out of range.
    assign req_nbytes = size_nbytes(size_i);
    assign req_end    = {1'b0, addr_i} + {{(ADDR_W-2){1'b0}}, req_nbytes};
    assign req_bad    = (size_i == SZ_RSVD)
                      | ((size_i == SZ_HALF) & addr_i[0])
                      | ((size_i == SZ_WORD) & (|addr_i[1:0]))
                      | (req_end > MEM_END);

    assign last_idx = size_nbytes(size_q) - 3'd1;
    assign wr_last  = ({1'b0, cnt_q} == last_idx);

    load_extend u_load_extend (
        .word_i     (mem_data_i),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .result_o   (ext_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    is_store_d = is_store_i;
                    size_d     = size_i;
                    unsigned_d = unsigned_i;
                    addr_d     = addr_i;
                    wdata_d    = wdata_i;
                    cnt_d      = '0;
                    if (req_bad) begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (is_store_i) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                rdata_d = ext_data;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_WR: begin
                if (wr_last) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (cnt_q)
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

    // Memory strobes decode straight from the state register so an async
    // reset removes them immediately.
    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        case (state_q)
            ST_RD_REQ: begin
                mem_read_o = 1'b1;
                mem_addr_o = addr_q;
            end
            ST_WR: begin
                mem_write_o = 1'b1;
                mem_addr_o  = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
                mem_data_o  = {24'b0, wr_byte};
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: byte-array memory model plus a
// reference image of memory and load results derived from the access rules.
module tb_dmem_access_unit;

    localparam int MEMB = 32;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        is_store_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_data_i;

    int tests  = 0;
    int failed = 0;

    logic [7:0]  mem     [MEMB];
    bit          mem_init = 1'b0;
    logic [7:0]  ref_mem [MEMB];
    logic [31:0] ref_rdata;

    dmem_access_unit #(.MEM_BYTES(MEMB), .ADDR_W(32)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .is_store_i  (is_store_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_data_i  (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (a + 32'(i) < 32'(MEMB)) w[8*i +: 8] = mem[5'(a + 32'(i))];
        return w;
    endfunction

    // Data memory: one byte per write, 4-byte little-endian registered read.
    always @(posedge clk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < MEMB; i++) mem[i] <= 8'((i * 37 + 5) % 256);
            mem_init   <= 1'b1;
            mem_data_i <= '0;
        end else begin
            if (mem_write_o && mem_addr_o < 32'(MEMB)) mem[mem_addr_o[4:0]] <= mem_data_o[7:0];
            if (mem_read_o) mem_data_i <= mem_word(mem_addr_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input int unsigned a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = 32'(ref_mem[a]);
            if (!uns && v >= 128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = 32'(ref_mem[a]) + 32'd256 * 32'(ref_mem[a+1]);
            if (!uns && v >= 32768) v = v - 32'd65536;
        end else begin
            v = 0;
            for (int i = 3; i >= 0; i--) v = v * 32'd256 + 32'(ref_mem[a+i]);
        end
        return v;
    endfunction

    task automatic do_op(input bit st, input logic [1:0] sz, input bit uns,
                         input int unsigned a, input logic [31:0] wd, input bit hold_start);
        int n, exp_done_s, exp_busy, nwr, nrd, busy_n, done_s;
        bit bad, err_seen;
        logic [31:0] wa  [8];
        logic [7:0]  wdv [8];
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        bad = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
              || (longint'(a) + longint'(n) > longint'(MEMB));
        exp_done_s = bad ? 1 : (st ? n + 1 : 3);
        exp_busy   = bad ? 1 : (st ? n : 2);
        nwr = 0; nrd = 0; busy_n = 0; done_s = 0; err_seen = 0;

        @(negedge clk_i);
        start_i = 1'b1; is_store_i = st; size_i = sz; unsigned_i = uns;
        addr_i = a; wdata_i = wd;
        @(posedge clk_i);
        #1;
        if (!hold_start) start_i = 1'b0;
        for (int s = 1; s <= 12 && done_s == 0; s++) begin
            @(negedge clk_i);
            if (busy_o) busy_n++;
            if (mem_write_o) begin
                if (nwr < 8) begin
                    wa[nwr]  = mem_addr_o;
                    wdv[nwr] = mem_data_o[7:0];
                end
                nwr++;
                chk("wr_data_upper", 32'(mem_data_o[31:8]), 32'd0);
            end
            if (mem_read_o) begin
                nrd++;
                chk("rd_addr", mem_addr_o, a);
            end
            chk("rd_wr_exclusive", 32'(mem_read_o & mem_write_o), 32'd0);
            if (!mem_read_o && !mem_write_o) begin
                chk("quiet_addr", mem_addr_o, 32'd0);
                chk("quiet_data", mem_data_o, 32'd0);
            end
            if (done_o) begin
                done_s   = s;
                err_seen = err_o;
            end else begin
                chk("err_without_done", 32'(err_o), 32'd0);
            end
        end
        start_i = 1'b0;

        chk("done_latency", done_s, exp_done_s);
        chk("busy_cycles", busy_n, exp_busy);
        chk("err_flag", 32'(err_seen), 32'(bad));
        chk("write_count", nwr, (st && !bad) ? n : 0);
        chk("read_count", nrd, (!st && !bad) ? 1 : 0);
        if (st && !bad) begin
            for (int k = 0; k < n && k < nwr; k++) begin
                chk("wr_addr", wa[k], a + 32'(k));
                chk("wr_byte", 32'(wdv[k]), (wd >> (8 * k)) & 32'hFF);
            end
            for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'((wd >> (8 * k)) & 32'hFF);
        end
        if (!st && !bad) ref_rdata = ref_load(sz, uns, a);
        chk("rdata", rdata_o, ref_rdata);

        @(negedge clk_i);
        chk("done_pulse_width", 32'(done_o), 32'd0);
        chk("err_pulse_width", 32'(err_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  rsz;
        int unsigned ra;
        int          rn;
        logic [31:0] rwd;

        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'((i * 37 + 5) % 256);
        ref_rdata  = 32'd0;
        rst_n_i    = 1'b0;
        start_i    = 1'b0;
        is_store_i = 1'b0;
        size_i     = 2'd0;
        unsigned_i = 1'b0;
        addr_i     = '0;
        wdata_i    = '0;

        repeat (3) @(negedge clk_i);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        chk("reset_mem_read", 32'(mem_read_o), 32'd0);
        chk("reset_mem_write", 32'(mem_write_o), 32'd0);
        rst_n_i = 1'b1;

        do_op(1, 2'd2, 0, 4, 32'h11223344, 0);
        do_op(0, 2'd2, 0, 4, 32'h0, 0);
        chk("plan_word_load", rdata_o, 32'h11223344);
        do_op(1, 2'd0, 0, 9, 32'h00000080, 0);
        do_op(0, 2'd0, 0, 9, 32'h0, 0);
        chk("plan_byte_signed", rdata_o, 32'hFFFFFF80);
        do_op(0, 2'd0, 1, 9, 32'h0, 0);
        chk("plan_byte_unsigned", rdata_o, 32'h00000080);
        do_op(1, 2'd1, 0, 10, 32'h0000BEEF, 0);
        do_op(0, 2'd1, 0, 10, 32'h0, 0);
        chk("plan_half_signed", rdata_o, 32'hFFFFBEEF);

        do_op(0, 2'd2, 0, 6, 32'h0, 0);
        do_op(0, 2'd1, 0, 3, 32'h0, 0);
        do_op(0, 2'd2, 0, 30, 32'h0, 0);
        do_op(0, 2'd3, 0, 8, 32'h0, 0);
        do_op(1, 2'd2, 0, 6, 32'hDEADBEEF, 0);
        do_op(1, 2'd1, 0, 32'hFFFFFFFE, 32'h1234, 0);
        do_op(0, 2'd0, 0, 32, 32'h0, 0);
        chk("plan_err_rdata_kept", rdata_o, 32'hFFFFBEEF);

        do_op(1, 2'd2, 0, 28, 32'hA5B6C7D8, 0);
        do_op(0, 2'd2, 0, 28, 32'h0, 0);
        do_op(0, 2'd0, 0, 31, 32'h0, 0);
        do_op(1, 2'd2, 0, 20, 32'hCAFEF00D, 1);
        do_op(0, 2'd1, 1, 30, 32'h0, 1);

        // Reset in the middle of a word store, while byte 2 is on the bus.
        @(negedge clk_i);
        start_i = 1'b1; is_store_i = 1'b1; size_i = 2'd2; unsigned_i = 1'b0;
        addr_i = 16; wdata_i = 32'h9A8B7C6D;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_pre_write", 32'(mem_write_o), 32'd1);
        chk("rst_pre_addr", mem_addr_o, 32'd18);
        rst_n_i = 1'b0;
        #1;
        chk("rst_async_write", 32'(mem_write_o), 32'd0);
        chk("rst_async_read", 32'(mem_read_o), 32'd0);
        chk("rst_async_busy", 32'(busy_o), 32'd0);
        chk("rst_async_done", 32'(done_o), 32'd0);
        chk("rst_async_rdata", rdata_o, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        ref_mem[16] = 8'h6D;
        ref_mem[17] = 8'h7C;
        ref_rdata   = 32'd0;
        @(negedge clk_i);
        chk("rst_no_done", 32'(done_o), 32'd0);
        do_op(0, 2'd2, 0, 16, 32'h0, 0);

        for (int t = 0; t < 40; t++) begin
            rsz = 2'($urandom_range(0, 3));
            rn  = (rsz == 2'd0) ? 1 : (rsz == 2'd1) ? 2 : 4;
            ra  = $urandom_range(0, 35);
            if ($urandom_range(0, 3) != 0) ra = ra - (ra % rn);
            rwd = $urandom;
            do_op(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, rwd,
                  ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
